// File: rtl/spoon_serial_tx.sv
// -----------------------------------------------------------------------------
// spoon_serial_tx
//
// Purpose:
//   Drains the maneuvering device's bytestream (0xCA id byte, 3-byte pointer
//   frames) into a small FIFO and serialises it as 8N1 asynchronous UART on a
//   single line. It models the pointing-device TXD wire that feeds the slave
//   controller's UART receiver. The bit period follows the same overclock
//   selection as the producer, so the producer byte rate and the line rate match
//   exactly.
//
// Parameters:
//   CLKS_PER_BIT     clk cycles per bit in normal mode (30 MHz / 1200 baud)
//   CLKS_PER_BIT_OC  clk cycles per bit when overclock is selected
//   FIFO_DEPTH       byte entries; power of two, >= 2
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   asynchronous assert, active-high reset
//   in_write    in   1   byte strobe from producer (no backpressure)
//   in_data     in   8   byte accompanying in_write
//   rts         in   1   level; high = flush FIFO, abort frame, hold line idle
//   overclock   in   1   selects CLKS_PER_BIT_OC for the next frame started
//   txd         out  1   serial line, idle high, LSB first
//   busy        out  1   frame on the line or FIFO non-empty (registered)
//   overflow    out  1   sticky: a byte was dropped because the FIFO was full
//
// Optional feature (macro SPOON_TX_STATS_EN):
//   tx_count    out  16  frames fully sent, wraps
//   drop_count  out  8   bytes dropped on a full FIFO, saturates at 0xFF
//   Both counters are cleared by reset only, not by rts.
// -----------------------------------------------------------------------------
module spoon_serial_tx #(
    parameter int CLKS_PER_BIT    = 25000,
    parameter int CLKS_PER_BIT_OC = 20000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_write,
    input  logic [7:0]  in_data,
    input  logic        rts,
    input  logic        overclock,
    output logic        txd,
    output logic        busy,
    output logic        overflow
`ifdef SPOON_TX_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [7:0]  drop_count
`endif
);

    localparam int MAX_CLKS = (CLKS_PER_BIT > CLKS_PER_BIT_OC) ? CLKS_PER_BIT : CLKS_PER_BIT_OC;
    localparam int CNT_W    = $clog2(MAX_CLKS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] PERIOD_NORMAL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] PERIOD_OC     = CNT_W'(CLKS_PER_BIT_OC);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE       = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;         // clocks elapsed in the current bit
    logic [CNT_W-1:0] period_q, period_d;   // bit period latched at frame start
    logic [2:0]       idx_q, idx_d;         // data bit index
    logic [7:0]       shift_q, shift_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic             overflow_q, overflow_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       head_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             bit_end;
    logic             pop;
    logic             push;
    logic             drop;

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // when the address bits coincide.
    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign fifo_full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign head_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign bit_end    = (cnt_q == (period_q - CNT_ONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        txd_d      = 1'b1;
        pop        = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        // busy reflects the state and FIFO as they stood before this edge,
        // so it trails its cause by one cycle.
        busy_d     = (state_q != S_IDLE) || !fifo_empty;

        if (rts) begin
            // Abort anything in flight, even mid-bit, and discard queued bytes.
            state_d    = S_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end
                end
                S_START: begin
                    txd_d = 1'b0;
                    if (bit_end) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    txd_d = shift_q[0];
                    if (bit_end) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        cnt_d   = '0;
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    txd_d = 1'b1;
                    if (bit_end) begin
                        cnt_d = '0;
                        // Chain straight into the next start bit when data is
                        // waiting, keeping frames back-to-back on the line.
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase

            if (pop) begin
                shift_d  = head_data;
                period_d = overclock ? PERIOD_OC : PERIOD_NORMAL;
                state_d  = S_START;
                cnt_d    = '0;
                idx_d    = '0;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            // A pop on the same edge frees the slot a full FIFO would refuse.
            push = in_write && (!fifo_full || pop);
            drop = in_write && !push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= PERIOD_NORMAL;
            idx_q      <= '0;
            shift_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    // Storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

`ifdef SPOON_TX_STATS_EN
    logic        frame_done;
    logic [15:0] tx_count_q, tx_count_d;
    logic [7:0]  drop_count_q, drop_count_d;

    // A frame counts only if its stop bit ran to completion without an abort.
    assign frame_done = !rts && (state_q == S_STOP) && bit_end;

    always_comb begin
        tx_count_d   = tx_count_q;
        drop_count_d = drop_count_q;
        if (frame_done) begin
            tx_count_d = tx_count_q + 16'd1;
        end
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            tx_count_q   <= tx_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tx_count   = tx_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_spoon_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_spoon_serial_tx
//
// Self-checking bench for spoon_serial_tx with short bit periods. A reference
// model predicts the line waveform from frame schedules: each accepted byte
// waits in a queue, a frame is taken when the line is free, and the expected
// txd level is the bit slot (start, 8 data LSB first, stop) that the current
// cycle falls into. busy, overflow and txd are compared every cycle.
// -----------------------------------------------------------------------------
module tb_spoon_serial_tx;

    localparam int P_N   = 8;
    localparam int P_OC  = 5;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_write;
    logic [7:0] in_data;
    logic       rts;
    logic       overclock;
    logic       txd;
    logic       busy;
    logic       overflow;
`ifdef SPOON_TX_STATS_EN
    logic [15:0] tx_count;
    logic [7:0]  drop_count;
`endif

    always #5 clk = ~clk;

    spoon_serial_tx #(
        .CLKS_PER_BIT    (P_N),
        .CLKS_PER_BIT_OC (P_OC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_write   (in_write),
        .in_data    (in_data),
        .rts        (rts),
        .overclock  (overclock),
        .txd        (txd),
        .busy       (busy),
        .overflow   (overflow)
`ifdef SPOON_TX_STATS_EN
        ,
        .tx_count   (tx_count),
        .drop_count (drop_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] mq[$];          // bytes accepted but not yet on the line
    int         cyc;            // index of the latest rising edge
    bit         f_valid;        // a frame schedule exists
    int         f_pop;          // edge at which the frame was taken
    int         f_per;          // its bit period
    logic [7:0] f_byte;
    bit         m_ovf;
    bit         m_busy_prev;
    int         m_tx;
    int         m_drop;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic exp_txd();
        int   o;
        int   b;
        logic v;
        v = 1'b1;
        if (f_valid) begin
            o = cyc - f_pop - 1;     // line lags the frame take by one edge
            if (o >= 0 && o < 10 * f_per) begin
                b = o / f_per;
                if (b == 0)      v = 1'b0;
                else if (b == 9) v = 1'b1;
                else             v = f_byte[b-1];
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        f_valid     = 1'b0;
        m_ovf       = 1'b0;
        m_busy_prev = 1'b0;
        m_tx        = 0;
        m_drop      = 0;
    endtask

    task automatic model_edge();
        bit pop;
        cyc++;
        if (rts) begin
            mq.delete();
            f_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (f_valid && cyc == f_pop + 10 * f_per) m_tx++;
            pop = (mq.size() > 0) && (!f_valid || cyc >= f_pop + 10 * f_per);
            if (pop) begin
                f_byte  = mq.pop_front();
                f_pop   = cyc;
                f_per   = overclock ? P_OC : P_N;
                f_valid = 1'b1;
            end
            if (in_write) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(in_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic tick();
        logic exp_busy;
        @(posedge clk);
        exp_busy = m_busy_prev;
        model_edge();
        m_busy_prev = (f_valid && (cyc < f_pop + 10 * f_per)) || (mq.size() > 0);
        @(negedge clk);
        chk("txd", txd, exp_txd());
        chk("busy", busy, exp_busy);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic put(input logic [7:0] d);
        in_write = 1'b1;
        in_data  = d;
        tick();
        in_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rts_pulse();
        rts = 1'b1;
        tick();
        rts = 1'b0;
    endtask

    initial begin
        int nb;
        int gap;
        reset     = 1'b1;
        in_write  = 1'b0;
        in_data   = 8'h00;
        rts       = 1'b0;
        overclock = 1'b0;
        cyc       = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        reset = 1'b0;
        idle(3);

        // Single 0xCA frame, normal period
        put(8'hCA);
        idle(10 * P_N + 6);

        // Three writes at the byte rate: frames back-to-back
        put(8'hC0);
        idle(10 * P_N - 1);
        put(8'h85);
        idle(10 * P_N - 1);
        put(8'h80);
        idle(10 * P_N + 6);
        chk("no_overflow", overflow, 1'b0);

        // Six consecutive writes: one taken, four queued, one dropped
        for (int i = 0; i < 6; i++) put(8'($urandom));
        chk("burst_overflow", overflow, 1'b1);
        idle(5 * 10 * P_N + 6);
        rts_pulse();
        idle(2);

        // Overclock at frame start, dropped mid-frame
        overclock = 1'b1;
        put(8'h3C);
        idle(3 * P_OC);
        overclock = 1'b0;
        idle(10 * P_OC);
        put(8'hA5);
        idle(10 * P_N + 6);

        // rts mid data bit 3 with two bytes queued
        put(8'h5A);
        put(8'h11);
        put(8'h22);
        idle(4 * P_N + P_N / 2 - 2);
        rts_pulse();
        idle(2);
        chk("rts_busy", busy, 1'b0);
        chk("rts_overflow", overflow, 1'b0);
        idle(3 * 10 * P_N);

        // Randomised traffic
        for (int k = 0; k < 16; k++) begin
            overclock = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                nb = int'($urandom_range(2, 6));
                for (int j = 0; j < nb; j++) put(8'($urandom));
            end else begin
                put(8'($urandom));
            end
            if ($urandom_range(0, 9) == 0) rts_pulse();
            gap = int'($urandom_range(0, 100));
            idle(gap);
        end
        overclock = 1'b0;
        idle(6 * 10 * P_N);

`ifdef SPOON_TX_STATS_EN
        chk_n("tx_count", int'(tx_count), m_tx);
        chk_n("drop_count", int'(drop_count), m_drop);
`endif

        // Asynchronous reset in the middle of a frame
        put(8'h00);
        idle(3 * P_N);
        #2 reset = 1'b1;
        #1;
        chk("async_txd", txd, 1'b1);
        chk("async_busy", busy, 1'b0);
        chk("async_overflow", overflow, 1'b0);
`ifdef SPOON_TX_STATS_EN
        chk_n("async_tx_count", int'(tx_count), 0);
        chk_n("async_drop_count", int'(drop_count), 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(4);
        put(8'hE7);
        idle(10 * P_N + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
